// File: rtl/bus_wait_sequencer.sv
// bus_wait_sequencer: 6502 system/VIA clock generator with a power-on hold
// and programmable wait-state stretching for slow I/O windows in page $9F.
module bus_wait_sequencer #(
    parameter int unsigned POR_CYCLES = 65535,
    parameter int unsigned WAIT_BITS  = 3,
    parameter logic [3:0]  REG0_NIB   = 4'h4,
    parameter logic [3:0]  REG1_NIB   = 4'h0,
    parameter logic [3:0]  REG2_NIB   = 4'h1,
    parameter logic [3:0]  REG3_NIB   = 4'h6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rw,
    input  logic [7:0] adrBusHi,
    input  logic [7:0] adrBusLo,
    input  logic [7:0] datBus,
    output logic [7:0] datOut,
    output logic       datOe,
    output logic       sysClk,
    output logic       viaClk,
    output logic       stretching,
    output logic       running
);

    localparam int unsigned POR_BITS = 16;

    typedef enum logic [1:0] {
        POR     = 2'd0,
        LOW     = 2'd1,
        HIGH    = 2'd2,
        STRETCH = 2'd3
    } state_t;

    state_t               state;
    logic [POR_BITS-1:0]  porCnt;
    logic [WAIT_BITS-1:0] waitCnt;
    logic [WAIT_BITS-1:0] waitReg [4];

    logic                 regionHit;
    logic [WAIT_BITS-1:0] regionWait;
    logic                 cfgSel;
    logic                 highPhase;
    logic                 highEnd;
    logic                 unusedDatBits;

    assign unusedDatBits = ^datBus[7:WAIT_BITS];

    // Region decode for the current address; lowest region index wins on collisions
    always_comb begin
        regionHit  = 1'b0;
        regionWait = '0;
        if (adrBusHi == 8'h9F) begin
            if (adrBusLo[7:4] == REG0_NIB) begin
                regionHit  = 1'b1;
                regionWait = waitReg[0];
            end else if (adrBusLo[7:4] == REG1_NIB) begin
                regionHit  = 1'b1;
                regionWait = waitReg[1];
            end else if (adrBusLo[7:4] == REG2_NIB) begin
                regionHit  = 1'b1;
                regionWait = waitReg[2];
            end else if (adrBusLo[7:4] == REG3_NIB) begin
                regionHit  = 1'b1;
                regionWait = waitReg[3];
            end
        end
    end

    assign cfgSel    = (adrBusHi == 8'h9F) && (adrBusLo[7:2] == 6'b011111);
    assign highPhase = (state == HIGH) || (state == STRETCH);
    // Last clk of the high phase, where the CPU access completes
    assign highEnd   = ((state == HIGH) && (waitCnt == '0)) ||
                       ((state == STRETCH) && (waitCnt == WAIT_BITS'(1)));

    // Register readback drives the bus only while the CPU reads during phi2 high
    assign datOe  = highPhase && rw && cfgSel;
    assign datOut = datOe ? 8'(waitReg[adrBusLo[1:0]]) : 8'h00;

    // Wait-count registers; writes commit as the CPU write completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waitReg[0] <= WAIT_BITS'(3);
            waitReg[1] <= '0;
            waitReg[2] <= '0;
            waitReg[3] <= '0;
        end else if (highEnd && !rw && cfgSel) begin
            waitReg[adrBusLo[1:0]] <= datBus[WAIT_BITS-1:0];
        end
    end

    // VIA clock runs at clk/2 once released from the power-on hold, never stretched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            viaClk <= 1'b0;
        end else if (running) begin
            viaClk <= ~viaClk;
        end
    end

    // Phase sequencer: POR hold, then LOW/HIGH with optional STRETCH clks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= POR;
            porCnt     <= '0;
            waitCnt    <= '0;
            sysClk     <= 1'b0;
            stretching <= 1'b0;
            running    <= 1'b0;
        end else begin
            case (state)
                POR: begin
                    if (porCnt == POR_BITS'(POR_CYCLES - 1)) begin
                        state   <= LOW;
                        running <= 1'b1;
                    end else begin
                        porCnt <= porCnt + POR_BITS'(1);
                    end
                end
                LOW: begin
                    waitCnt <= regionHit ? regionWait : '0;
                    state   <= HIGH;
                    sysClk  <= 1'b1;
                end
                HIGH: begin
                    if (waitCnt == '0) begin
                        state  <= LOW;
                        sysClk <= 1'b0;
                    end else begin
                        state      <= STRETCH;
                        stretching <= 1'b1;
                    end
                end
                STRETCH: begin
                    waitCnt <= waitCnt - WAIT_BITS'(1);
                    if (waitCnt == WAIT_BITS'(1)) begin
                        state      <= LOW;
                        sysClk     <= 1'b0;
                        stretching <= 1'b0;
                    end
                end
                default: begin
                    state <= POR;
                end
            endcase
        end
    end

endmodule
